wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/wb_arbiter2.sv | 134 +++++++++++++
 tb/tb_wb_arbiter2.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// ============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared state encodings and grant codes for the two-master
//            Wishbone arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_IDLE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage : wb_arb_pkg

`default_nettype wire

// File: rtl/wb_arbiter2.sv
// ============================================================================
// Module   : wb_arbiter2
// Purpose  : Two-master Wishbone arbiter (m0 = CPU core, m1 = debug engine)
//            with a registered owner FSM and a combinational bus mux.
//            Define WB_ARB_ROUND_ROBIN_EN to alternate simultaneous winners;
//            otherwise m0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int ADDR_WIDTH = 32,
  localparam int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // master 0 (CPU core)
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [SEL_WIDTH-1:0]  m0_sel_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  // master 1 (debug engine)
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [SEL_WIDTH-1:0]  m1_sel_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  // interconnect side
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [SEL_WIDTH-1:0]  s_sel_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  output logic [1:0]            gnt_o
);

  arb_state_e state_q, state_d;
  logic       pick_m1;

`ifdef WB_ARB_ROUND_ROBIN_EN
  // last_q = 1 means m1 owned the bus most recently
  logic last_q, last_d;

  assign pick_m1 = m1_cyc_i & (~m0_cyc_i | ~last_q);

  always_comb begin
    last_d = last_q;
    if (state_q == ST_IDLE) begin
      if (state_d == ST_OWN1)      last_d = 1'b1;
      else if (state_d == ST_OWN0) last_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  assign pick_m1 = m1_cyc_i & ~m0_cyc_i;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_m1)       state_d = ST_OWN1;
        else if (m0_cyc_i) state_d = ST_OWN0;
      end
      ST_OWN0: if (!m0_cyc_i) state_d = ST_IDLE;
      ST_OWN1: if (!m1_cyc_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Mux keys off the registered owner, so an ack arriving as cyc drops still lands.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    gnt_o    = GNT_IDLE;
    case (state_q)
      ST_OWN0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        gnt_o    = GNT_M0;
      end
      ST_OWN1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        gnt_o    = GNT_M1;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule : wb_arbiter2

`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
// ============================================================================
// Module   : tb_wb_arbiter2
// Purpose  : Directed self-checking bench for wb_arbiter2 with a read-data
//            scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [31:0] m0_adr_i = '0;
  logic [1:0]  m0_sel_i = '0;
  logic [15:0] m0_dat_i = '0;
  logic [15:0] m0_dat_o;
  logic        m0_ack_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [31:0] m1_adr_i = '0;
  logic [1:0]  m1_sel_i = '0;
  logic [15:0] m1_dat_i = '0;
  logic [15:0] m1_dat_o;
  logic        m1_ack_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o;
  logic [1:0]  s_sel_o;
  logic [15:0] s_dat_o;
  logic [15:0] s_dat_i = '0;
  logic        s_ack_i = 1'b0;
  logic [1:0]  gnt_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        m;
    logic [15:0] d;
  } exp_t;
  exp_t sb[$];

  wb_arbiter2 #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_sel_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_sel_i = '0;
    s_ack_i = 0; s_dat_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Counts negedges until any grant appears; 99 marks an expired bound.
  task automatic wait_grant(output logic [1:0] g, output int n);
    g = 2'b00;
    n = 0;
    while (n < 8) begin
      @(negedge clk_i);
      n++;
      if (gnt_o !== 2'b00) begin
        g = gnt_o;
        break;
      end
    end
    if (g == 2'b00) n = 99;
  endtask

  // Interconnect returns data; the scoreboard says which master must see it.
  task automatic slave_ack(input string tag, input logic [15:0] d);
    exp_t e;
    s_ack_i = 1'b1;
    s_dat_i = d;
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_ack0"}, {31'd0, m0_ack_o}, {31'd0, ~e.m});
      chk({tag, "_ack1"}, {31'd0, m1_ack_o}, {31'd0, e.m});
      chk({tag, "_dat"}, {16'd0, (e.m ? m1_dat_o : m0_dat_o)}, {16'd0, e.d});
    end
    @(negedge clk_i);
    s_ack_i = 1'b0;
    s_dat_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g;
    int         n;
    logic [1:0] exp_seq [3];

    // ---------------- reset state
    do_reset();
    chk("rst_gnt", {30'd0, gnt_o}, 32'd0);
    chk("rst_scyc", {31'd0, s_cyc_o}, 32'd0);
    chk("rst_sstb", {31'd0, s_stb_o}, 32'd0);
    chk("rst_acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);

    // ---------------- single m0 read
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_1000; m0_sel_i = 2'b11;
    sb.push_back('{m: 1'b0, d: 16'hBEEF});
    #1;
    chk("rd_idle_scyc", {31'd0, s_cyc_o}, 32'd0);
    chk("rd_idle_sadr", s_adr_o, 32'd0);
    wait_grant(g, n);
    chk("rd_lat", n, 32'd1);
    chk("rd_gnt", {30'd0, g}, 32'h1);
    chk("rd_sadr", s_adr_o, 32'h0000_1000);
    chk("rd_scyc", {31'd0, s_cyc_o}, 32'd1);
    @(negedge clk_i);
    chk("rd_wait_ack1", {31'd0, m1_ack_o}, 32'd0);
    slave_ack("rd", 16'hBEEF);
    chk("rd_bcast_m1dat", {16'd0, m1_dat_o}, 32'd0);
    m0_cyc_i = 0; m0_stb_i = 0;
    @(negedge clk_i);
    chk("rd_back_idle", {30'd0, gnt_o}, 32'd0);

    // ---------------- simultaneous after reset, m0 first, then m1
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_2000;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_3000;
    sb.push_back('{m: 1'b0, d: 16'h1111});
    sb.push_back('{m: 1'b1, d: 16'h2222});
    wait_grant(g, n);
    chk("sim_lat", n, 32'd1);
    chk("sim_first", {30'd0, g}, 32'h1);
    chk("sim_sadr0", s_adr_o, 32'h0000_2000);
    slave_ack("sim0", 16'h1111);
    m0_cyc_i = 0; m0_stb_i = 0;
    @(negedge clk_i);
    chk("sim_dead", {30'd0, gnt_o}, 32'd0);
    @(negedge clk_i);
    chk("sim_second", {30'd0, gnt_o}, 32'h2);
    chk("sim_sadr1", s_adr_o, 32'h0000_3000);
    slave_ack("sim1", 16'h2222);
    m1_cyc_i = 0; m1_stb_i = 0;
    @(negedge clk_i);

    // ---------------- repeated simultaneous requests
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
`else
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) begin
      m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
      wait_grant(g, n);
      chk($sformatf("rep%0d_lat", i), n, 32'd1);
      chk($sformatf("rep%0d_gnt", i), {30'd0, g}, {30'd0, exp_seq[i]});
      m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
      @(negedge clk_i);
      chk($sformatf("rep%0d_idle", i), {30'd0, gnt_o}, 32'd0);
    end

    // ---------------- m1 locked over 3 strobes while m0 waits
    do_reset();
    m1_cyc_i = 1;
    wait_grant(g, n);
    chk("lock_gnt", {30'd0, g}, 32'h2);
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'hDEAD_0000;
    for (int i = 0; i < 3; i++) begin
      m1_stb_i = 1; m1_adr_i = 32'h0000_4000 + 32'(i * 2);
      sb.push_back('{m: 1'b1, d: 16'(16'hA000 + i)});
      #1;
      chk($sformatf("lock%0d_sadr", i), s_adr_o, 32'h0000_4000 + 32'(i * 2));
      slave_ack($sformatf("lock%0d", i), 16'(16'hA000 + i));
      m1_stb_i = 0;
      #1;
      chk($sformatf("lock%0d_gnt", i), {30'd0, gnt_o}, 32'h2);
      chk($sformatf("lock%0d_sadr_gap", i), s_adr_o, 32'h0000_4000 + 32'(i * 2));
      @(negedge clk_i);
    end
    m1_cyc_i = 0;
    @(negedge clk_i);
    chk("lock_release_idle", {30'd0, gnt_o}, 32'd0);
    @(negedge clk_i);
    chk("lock_m0_gnt", {30'd0, gnt_o}, 32'h1);
    chk("lock_m0_sadr", s_adr_o, 32'hDEAD_0000);
    m0_cyc_i = 0; m0_stb_i = 0;
    @(negedge clk_i);

    // ---------------- reset while m1 waits on ack
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_5000;
    wait_grant(g, n);
    chk("rstmid_gnt", {30'd0, g}, 32'h2);
    rst_i = 1;
    @(negedge clk_i);
    chk("rstmid_gnt0", {30'd0, gnt_o}, 32'd0);
    chk("rstmid_scyc", {31'd0, s_cyc_o}, 32'd0);
    s_ack_i = 1; s_dat_i = 16'h5A5A;
    #1;
    chk("rstmid_late_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
    s_ack_i = 0; s_dat_i = '0; m1_cyc_i = 0; m1_stb_i = 0;
    @(negedge clk_i);
    rst_i = 0;

    // ---------------- cyc drops in the same cycle as ack
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_6000;
    wait_grant(g, n);
    chk("drop_gnt", {30'd0, g}, 32'h1);
    m0_cyc_i = 0; m0_stb_i = 0;
    sb.push_back('{m: 1'b0, d: 16'h1234});
    slave_ack("drop", 16'h1234);
    chk("drop_idle", {30'd0, gnt_o}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wb_arbiter2

`default_nettype wire
